// File: rtl/phase_scheduler_if.sv
// Signal bundle between a traffic-phase scheduler and its environment.
// The master drives the tick, emergency and pedestrian inputs; the slave (the scheduler) drives the lights and countdowns.
interface phase_scheduler_if;
    logic       tick;
    logic       maj_emg;
    logic       min_emg;
    logic       ped_req;
    logic [2:0] maj_light;
    logic [2:0] min_light;
    logic [5:0] maj_cnt;
    logic [5:0] min_cnt;
    logic       ped_pending;

    modport master (
        output tick, maj_emg, min_emg, ped_req,
        input  maj_light, min_light, maj_cnt, min_cnt, ped_pending
    );

    modport slave (
        input  tick, maj_emg, min_emg, ped_req,
        output maj_light, min_light, maj_cnt, min_cnt, ped_pending
    );
endinterface

// File: rtl/phase_scheduler.sv
// Two-road traffic phase scheduler with emergency preemption and countdown displays.
// Define PED_REQ_EN to compile in pedestrian request latching and major-green shortening.
module phase_scheduler #(
    parameter int MAJ_GREEN = 30,
    parameter int MIN_GREEN = 20,
    parameter int YELLOW    = 5,
    parameter int CLR       = 2,
    parameter int PED_MIN   = 5
) (
    input logic               clk,
    input logic               rst,
    phase_scheduler_if.slave  bus
);

    typedef enum logic [2:0] {
        ALL_RED = 3'd0,
        MAJ_G   = 3'd1,
        MAJ_Y   = 3'd2,
        MIN_G   = 3'd3,
        MIN_Y   = 3'd4,
        EMG_MAJ = 3'd5,
        EMG_MIN = 3'd6
    } state_t;

    localparam logic [5:0] D_MAJ = 6'(MAJ_GREEN);
    localparam logic [5:0] D_MIN = 6'(MIN_GREEN);
    localparam logic [5:0] D_YEL = 6'(YELLOW);
    localparam logic [5:0] D_CLR = 6'(CLR);
    localparam logic [5:0] D_PED = 6'(PED_MIN);

    localparam logic [2:0] LT_R = 3'b100;
    localparam logic [2:0] LT_Y = 3'b010;
    localparam logic [2:0] LT_G = 3'b001;

    state_t     state_r;
    state_t     state_nx_s;
    logic [5:0] cnt_r;
    logic [5:0] cnt_nx_s;
    logic       ped_r;
    logic       ped_keep_s;
    logic       ped_nx_s;
    logic [2:0] maj_light_r;
    logic [2:0] min_light_r;
    logic [5:0] maj_cnt_r;
    logic [5:0] min_cnt_r;

    function automatic state_t follow(input state_t s);
        case (s)
            ALL_RED: return MAJ_G;
            MAJ_G:   return MAJ_Y;
            MAJ_Y:   return MIN_G;
            MIN_G:   return MIN_Y;
            MIN_Y:   return MAJ_G;
            default: return ALL_RED;
        endcase
    endfunction

    function automatic logic [5:0] dur_of(input state_t s);
        case (s)
            ALL_RED: return D_CLR;
            MAJ_G:   return D_MAJ;
            MAJ_Y:   return D_YEL;
            MIN_G:   return D_MIN;
            MIN_Y:   return D_YEL;
            default: return 6'd0;
        endcase
    endfunction

    function automatic logic [2:0] maj_light_of(input state_t s);
        case (s)
            MAJ_G, EMG_MAJ: return LT_G;
            MAJ_Y:          return LT_Y;
            default:        return LT_R;
        endcase
    endfunction

    function automatic logic [2:0] min_light_of(input state_t s);
        case (s)
            MIN_G, EMG_MIN: return LT_G;
            MIN_Y:          return LT_Y;
            default:        return LT_R;
        endcase
    endfunction

    // The red road during the other road's green also counts through the coming yellow.
    function automatic logic [5:0] maj_cnt_of(input state_t s, input logic [5:0] c);
        case (s)
            ALL_RED, MAJ_G, MAJ_Y, MIN_Y: return c;
            MIN_G:                        return c + D_YEL;
            default:                      return 6'd0;
        endcase
    endfunction

    function automatic logic [5:0] min_cnt_of(input state_t s, input logic [5:0] c);
        case (s)
            ALL_RED, MIN_G, MIN_Y, MAJ_Y: return c;
            MAJ_G:                        return c + D_YEL;
            default:                      return 6'd0;
        endcase
    endfunction

`ifdef PED_REQ_EN
    // Latch a pedestrian request; MIN_G already serves the crossing.
    always_comb begin
        ped_keep_s = ped_r;
        if (bus.ped_req && (state_r != MIN_G)) begin
            ped_keep_s = 1'b1;
        end else begin
            ped_keep_s = ped_r;
        end
    end
`else
    logic unused_ped_s;
    assign unused_ped_s = bus.ped_req;
    assign ped_keep_s   = 1'b0;
`endif

    // Next phase: emergencies first, then emergency exit, then shortening, then the tick countdown.
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r;
        if (bus.maj_emg) begin
            state_nx_s = EMG_MAJ;
            cnt_nx_s   = 6'd0;
        end else if (bus.min_emg) begin
            state_nx_s = EMG_MIN;
            cnt_nx_s   = 6'd0;
        end else if ((state_r == EMG_MAJ) || (state_r == EMG_MIN)) begin
            state_nx_s = ALL_RED;
            cnt_nx_s   = D_CLR;
`ifdef PED_REQ_EN
        end else if ((state_r == MAJ_G) && ped_keep_s && (cnt_r > D_PED)) begin
            cnt_nx_s   = D_PED;
`endif
        end else if (bus.tick) begin
            if (cnt_r == 6'd1) begin
                state_nx_s = follow(state_r);
                cnt_nx_s   = dur_of(follow(state_r));
            end else begin
                cnt_nx_s   = cnt_r - 6'd1;
            end
        end else begin
            state_nx_s = state_r;
            cnt_nx_s   = cnt_r;
        end
    end

    // Entering MIN_G serves any pending crossing.
    always_comb begin
        ped_nx_s = ped_keep_s;
        if ((state_nx_s == MIN_G) && (state_r != MIN_G)) begin
            ped_nx_s = 1'b0;
        end else begin
            ped_nx_s = ped_keep_s;
        end
    end

    // State, counter and all outputs update together so the displays always match the phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ALL_RED;
            cnt_r       <= D_CLR;
            ped_r       <= 1'b0;
            maj_light_r <= LT_R;
            min_light_r <= LT_R;
            maj_cnt_r   <= D_CLR;
            min_cnt_r   <= D_CLR;
        end else begin
            state_r     <= state_nx_s;
            cnt_r       <= cnt_nx_s;
            ped_r       <= ped_nx_s;
            maj_light_r <= maj_light_of(state_nx_s);
            min_light_r <= min_light_of(state_nx_s);
            maj_cnt_r   <= maj_cnt_of(state_nx_s, cnt_nx_s);
            min_cnt_r   <= min_cnt_of(state_nx_s, cnt_nx_s);
        end
    end

    assign bus.maj_light   = maj_light_r;
    assign bus.min_light   = min_light_r;
    assign bus.maj_cnt     = maj_cnt_r;
    assign bus.min_cnt     = min_cnt_r;
    assign bus.ped_pending = ped_r;

endmodule

// File: tb/tb_phase_scheduler.sv
// Scoreboard bench for phase_scheduler: directed scenarios followed by random traffic,
// every cycle compared against a table-driven phase model.
module tb_phase_scheduler;

    localparam int MAJ_GREEN = 30;
    localparam int MIN_GREEN = 20;
    localparam int YELLOW    = 5;
    localparam int CLR       = 2;
    localparam int PED_MIN   = 5;
`ifdef PED_REQ_EN
    localparam bit PED_ON = 1'b1;
`else
    localparam bit PED_ON = 1'b0;
`endif

    localparam int P_AR = 0, P_MG = 1, P_MY = 2, P_NG = 3, P_NY = 4, P_EM = 5, P_EN = 6;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    phase_scheduler_if bus ();

    phase_scheduler #(
        .MAJ_GREEN(MAJ_GREEN), .MIN_GREEN(MIN_GREEN), .YELLOW(YELLOW),
        .CLR(CLR), .PED_MIN(PED_MIN)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct packed {
        logic [2:0] ml;
        logic [2:0] nl;
        logic [5:0] mc;
        logic [5:0] nc;
        logic       pp;
    } exp_t;

    exp_t sb_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // reference model: phase index, remaining seconds, pending crossing
    int m_ph;
    int m_rem;
    bit m_pend;
    bit cur_me;
    bit cur_ne;

    // lights per phase index {AR,MG,MY,NG,NY,EM,EN}
    logic [2:0] maj_tab [7] = '{3'b100, 3'b001, 3'b010, 3'b100, 3'b100, 3'b001, 3'b100};
    logic [2:0] min_tab [7] = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100, 3'b001};
    int         dur_tab [5] = '{CLR, MAJ_GREEN, YELLOW, MIN_GREEN, YELLOW};
    int         nxt_tab [5] = '{P_MG, P_MY, P_NG, P_NY, P_MG};

    function automatic void model_step(bit t, bit me, bit ne, bit pr, bit r);
        int  old_ph;
        bit  pend;
        if (r) begin
            m_ph = P_AR; m_rem = CLR; m_pend = 1'b0;
            return;
        end
        old_ph = m_ph;
        pend   = m_pend | (PED_ON & pr & (m_ph != P_NG));
        if (me) begin
            m_ph = P_EM; m_rem = 0;
        end else if (ne) begin
            m_ph = P_EN; m_rem = 0;
        end else if (m_ph >= P_EM) begin
            m_ph = P_AR; m_rem = CLR;
        end else if (m_ph == P_MG && pend && m_rem > PED_MIN) begin
            m_rem = PED_MIN;
        end else if (t) begin
            if (m_rem == 1) begin
                m_ph  = nxt_tab[m_ph];
                m_rem = dur_tab[m_ph];
            end else begin
                m_rem = m_rem - 1;
            end
        end
        if (m_ph == P_NG && old_ph != P_NG) pend = 1'b0;
        m_pend = pend;
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        e.ml = maj_tab[m_ph];
        e.nl = min_tab[m_ph];
        e.pp = m_pend;
        e.mc = 6'(m_rem);
        e.nc = 6'(m_rem);
        if (m_ph >= P_EM) begin
            e.mc = 6'd0; e.nc = 6'd0;
        end else if (m_ph == P_MG) begin
            e.nc = 6'(m_rem + YELLOW);
        end else if (m_ph == P_NG) begin
            e.mc = 6'(m_rem + YELLOW);
        end
        return e;
    endfunction

    // monitor: one expected entry per clock edge
    exp_t mon_e;
    exp_t mon_g;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                mon_e = sb_q.pop_front();
                mon_g = {bus.maj_light, bus.min_light, bus.maj_cnt, bus.min_cnt, bus.ped_pending};
                vectors++;
                if (mon_g !== mon_e) begin
                    miscompares++;
                    $display("FAIL scoreboard t=%0t got ml=%b nl=%b mc=%0d nc=%0d pp=%b expected ml=%b nl=%b mc=%0d nc=%0d pp=%b",
                             $time, mon_g.ml, mon_g.nl, mon_g.mc, mon_g.nc, mon_g.pp,
                             mon_e.ml, mon_e.nl, mon_e.mc, mon_e.nc, mon_e.pp);
                end
            end
        end
    end

    task automatic drive(input bit t, input bit me, input bit ne, input bit pr, input bit r);
        @(negedge clk);
        bus.tick    = t;
        bus.maj_emg = me;
        bus.min_emg = ne;
        bus.ped_req = pr;
        rst         = r;
        model_step(t, me, ne, pr, r);
        sb_q.push_back(model_out());
        @(posedge clk);
        #2;
    endtask

    task automatic spot(input string nm, input int got, input int exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, cur_me, cur_ne, 1'b0, 1'b0);
            if ($urandom_range(1, 0) == 1) drive(1'b0, cur_me, cur_ne, 1'b0, 1'b0);
        end
    endtask

    task automatic run_to(input int ph);
        int g;
        g = 0;
        while (m_ph != ph && g < 400) begin
            tick_n(1);
            g++;
        end
        vectors++;
        if (m_ph != ph) begin
            miscompares++;
            $display("FAIL run_to: phase %0d not reached, at %0d", ph, m_ph);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        bit t, pr, r;
        bus.tick = 1'b0; bus.maj_emg = 1'b0; bus.min_emg = 1'b0; bus.ped_req = 1'b0;
        rst = 1'b1; cur_me = 1'b0; cur_ne = 1'b0;
        m_ph = P_AR; m_rem = CLR; m_pend = 1'b0;

        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        spot("rst_maj_light", int'(bus.maj_light), 4);
        spot("rst_min_light", int'(bus.min_light), 4);
        spot("rst_maj_cnt", int'(bus.maj_cnt), CLR);
        spot("rst_min_cnt", int'(bus.min_cnt), CLR);
        spot("rst_ped", int'(bus.ped_pending), 0);

        tick_n(2);
        spot("majg_light", int'(bus.maj_light), 1);
        spot("majg_cnt", int'(bus.maj_cnt), 30);
        spot("majg_min_cnt", int'(bus.min_cnt), 35);
        tick_n(30);
        spot("majy_light", int'(bus.maj_light), 2);
        spot("majy_cnt", int'(bus.maj_cnt), 5);
        spot("majy_min_cnt", int'(bus.min_cnt), 5);
        tick_n(5);
        spot("ming_light", int'(bus.min_light), 1);
        spot("ming_cnt", int'(bus.min_cnt), 20);
        spot("ming_maj_cnt", int'(bus.maj_cnt), 25);
        tick_n(20);
        spot("miny_light", int'(bus.min_light), 2);
        tick_n(5);
        spot("cycle_majg_light", int'(bus.maj_light), 1);
        spot("cycle_majg_cnt", int'(bus.maj_cnt), 30);

        tick_n(10);
        spot("pre_ped_cnt", int'(bus.maj_cnt), 20);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        spot("ped_set", int'(bus.ped_pending), int'(PED_ON));
        spot("ped_short_cnt", int'(bus.maj_cnt), PED_ON ? 5 : 20);
        run_to(P_NG);
        spot("ped_clear_ming", int'(bus.ped_pending), 0);

        tick_n(3);
        cur_me = 1'b1;
        drive(1'b0, cur_me, cur_ne, 1'b0, 1'b0);
        spot("emg_maj_light", int'(bus.maj_light), 1);
        spot("emg_maj_cnt", int'(bus.maj_cnt), 0);
        spot("emg_min_cnt", int'(bus.min_cnt), 0);
        tick_n(3);
        cur_me = 1'b0;
        drive(1'b0, cur_me, cur_ne, 1'b0, 1'b0);
        spot("emg_exit_light", int'(bus.maj_light), 4);
        spot("emg_exit_cnt", int'(bus.maj_cnt), 2);
        tick_n(2);
        spot("emg_resume_cnt", int'(bus.maj_cnt), 30);

        cur_me = 1'b1; cur_ne = 1'b1;
        drive(1'b0, cur_me, cur_ne, 1'b0, 1'b0);
        spot("both_emg_maj", int'(bus.maj_light), 1);
        cur_me = 1'b0;
        drive(1'b0, cur_me, cur_ne, 1'b0, 1'b0);
        spot("handover_min_light", int'(bus.min_light), 1);
        spot("handover_maj_light", int'(bus.maj_light), 4);
        drive(1'b1, cur_me, cur_ne, 1'b1, 1'b1);
        spot("rst_in_emg_light", int'(bus.min_light), 4);
        spot("rst_in_emg_cnt", int'(bus.maj_cnt), CLR);
        spot("rst_in_emg_ped", int'(bus.ped_pending), 0);
        drive(1'b0, cur_me, cur_ne, 1'b0, 1'b0);
        spot("emg_min_reentry", int'(bus.min_light), 1);
        cur_ne = 1'b0;
        drive(1'b0, cur_me, cur_ne, 1'b0, 1'b0);
        spot("emg_min_exit_cnt", int'(bus.min_cnt), 2);

        run_to(P_MG);
        tick_n(MAJ_GREEN - 3);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        spot("ped_late_cnt", int'(bus.maj_cnt), 3);
        spot("ped_late_set", int'(bus.ped_pending), int'(PED_ON));
        run_to(P_NG);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        spot("ped_in_ming_ignored", int'(bus.ped_pending), 0);

        for (int i = 0; i < 4000; i++) begin
            t  = ($urandom_range(1, 0) == 1);
            pr = ($urandom_range(19, 0) == 0);
            r  = ($urandom_range(499, 0) == 0);
            if (cur_me) cur_me = ($urandom_range(9, 0) != 0);
            else        cur_me = ($urandom_range(149, 0) == 0);
            if (cur_ne) cur_ne = ($urandom_range(9, 0) != 0);
            else        cur_ne = ($urandom_range(149, 0) == 0);
            drive(t, cur_me, cur_ne, pr, r);
        end

        @(posedge clk);
        #3;
        spot("scoreboard_drained", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/phase_scheduler.md
PHASE_SCHEDULER -- requirements
Module: phase_scheduler

Interface
REQ-001 Parameter MAJ_GREEN, 30, major-road green duration in ticks.
REQ-002 Parameter MIN_GREEN, 20, minor-road green duration in ticks.
REQ-003 Parameter YELLOW, 5, yellow duration in ticks (both roads).
REQ-004 Parameter CLR, 2, all-red clearance duration in ticks.
REQ-005 Parameter PED_MIN, 5, major green remaining time after pedestrian shortening.
REQ-006 Port clk  input  1  system clock; single clock domain.
REQ-007 Port rst  input  1  reset, synchronous to clk and active-high.
REQ-008 Port tick  input  1  one-clk-wide 1 Hz enable pulse.
REQ-009 Port maj_emg  input  1  debounced major-road emergency level.
REQ-010 Port min_emg  input  1  debounced minor-road emergency level.
REQ-011 Port ped_req  input  1  one-clk pedestrian crossing request pulse.
REQ-012 Port maj_light  output  3  major lights {R,Y,G}, one-hot.
REQ-013 Port min_light  output  3  minor lights {R,Y,G}, one-hot.
REQ-014 Port maj_cnt  output  6  major countdown, binary.
REQ-015 Port min_cnt  output  6  minor countdown, binary.
REQ-016 Port ped_pending  output  1  latched, not-yet-served pedestrian request.

Function
REQ-017 States SHALL be ALL_RED, MAJ_G, MAJ_Y, MIN_G, MIN_Y, EMG_MAJ, EMG_MIN; all outputs registered.
REQ-018 Internal counter cnt SHALL load the state duration on entry; each tick decrements it; a tick with cnt==1 transitions and loads the next duration.
REQ-019 Normal cycle SHALL be ALL_RED(CLR) -> MAJ_G(MAJ_GREEN) -> MAJ_Y(YELLOW) -> MIN_G(MIN_GREEN) -> MIN_Y(YELLOW) -> MAJ_G.
REQ-020 Lights: green road 001, yellow road 010, opposite road 100; ALL_RED both 100; EMG_MAJ major 001/minor 100; EMG_MIN the mirror.
REQ-021 Countdown: active road shows cnt; red road shows cnt+YELLOW during green, cnt during yellow; ALL_RED both show cnt; emergency states both show 0.
REQ-022 maj_emg high SHALL force EMG_MAJ on the next clk from any state, ignoring tick; else min_emg high SHALL force EMG_MIN.
REQ-023 Both emergencies high: major wins; EMG_MAJ with maj_emg falling and min_emg high SHALL go to EMG_MIN next clk.
REQ-024 Both emergencies low in an emergency state SHALL enter ALL_RED with cnt=CLR next clk.
REQ-025 ped_req SHALL set ped_pending unless state is MIN_G; ped_pending clears on entry to MIN_G.
REQ-026 In MAJ_G with ped_pending and cnt>PED_MIN, cnt SHALL load PED_MIN on the next clk; shortening beats a coincident tick.
REQ-027 ped_pending SHALL persist across emergency states and ALL_RED.
REQ-028 Parameters SHALL satisfy MAJ_GREEN+YELLOW<=63, MIN_GREEN+YELLOW<=63, all durations >=1; no wrap of cnt below 1.

Reset
REQ-029 rst high at a clk edge SHALL override all inputs, including tick and emergencies.
REQ-030 Reset values: state ALL_RED, cnt=CLR, maj_light=min_light=100, maj_cnt=min_cnt=CLR, ped_pending=0.
REQ-031 Reset mid-phase or mid-emergency SHALL discard the phase; the cycle restarts at ALL_RED.

Configuration
REQ-032 Macro PED_REQ_EN defined: pedestrian latching and shortening per REQ-025..027 are compiled in.
REQ-033 PED_REQ_EN undefined: ped_req ignored, ped_pending tied 0, MAJ_G always lasts MAJ_GREEN ticks.

Verification
REQ-034 Reset, then 2 ticks -> MAJ_G, maj_light=001, maj_cnt=30, min_cnt=35; 30 more ticks -> MAJ_Y, maj_cnt=5, min_cnt=5.
REQ-035 Full cycle with default parameters -> MAJ_G reentered after 30+5+20+5 ticks; min_light=001 only in MIN_G, min_cnt counts 20..1.
REQ-036 maj_emg pulses high mid-MIN_G, held 3 ticks -> EMG_MAJ next clk, counts 0; on release ALL_RED with cnt 2, then MAJ_G with cnt 30.
REQ-037 maj_emg and min_emg both high -> EMG_MAJ; drop maj_emg -> EMG_MIN next clk, min_light=001.
REQ-038 PED_REQ_EN on, ped_req at MAJ_G cnt=20 -> ped_pending=1, cnt=5 next clk; cnt=3 case -> unchanged; MIN_G entry clears ped_pending.
REQ-039 rst asserted in EMG_MIN while min_emg high -> ALL_RED reset values next clk; EMG_MIN reentered the clk after rst drops.
